ov7670_capture: RTL and testbench



---
 rtl/ov7670_pkg.sv | 26 ++
 rtl/ov7670_sync.sv | 80 ++++++++
 rtl/ov7670_capture.sv | 166 ++++++++++++++++
 tb/tb_ov7670_capture.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ov7670_pkg                                                  |
// | Brief   : Shared widths, FSM encoding and pixel packing helper for    |
// |           the OV7670 capture path.                                    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package ov7670_pkg;

    localparam int RGB565_W  = 16;
    localparam int OV_DATA_W = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    // The camera delivers the high byte first on every pixel.
    function automatic logic [RGB565_W-1:0] rgb565_pack(
        input logic [OV_DATA_W-1:0] hi,
        input logic [OV_DATA_W-1:0] lo
    );
        return {hi, lo};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ov7670_sync                                                 |
// | Brief   : Synchronizer bank for the camera pins with registered edge  |
// |           detects, keeping data aligned with pclk/href/vsync.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ov7670_sync
    import ov7670_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pclk_in,
    input  logic                 href_in,
    input  logic                 vsync_in,
    input  logic [OV_DATA_W-1:0] data_in,
    output logic                 pclk_rise,
    output logic                 href_lvl,
    output logic                 href_fall,
    output logic                 vsync_rise,
    output logic                 vsync_fall,
    output logic [OV_DATA_W-1:0] data_out
);

    localparam int BUS_W = OV_DATA_W + 3;

    logic [BUS_W-1:0]     r_chain [SYNC_STAGES];
    logic                 r_pclk_prev;
    logic                 r_href_prev;
    logic                 r_vsync_prev;

    logic [BUS_W-1:0]     w_tail;
    logic                 w_pclk;
    logic                 w_href;
    logic                 w_vsync;
    logic [OV_DATA_W-1:0] w_data;

    assign w_tail  = r_chain[SYNC_STAGES-1];
    assign w_pclk  = w_tail[BUS_W-1];
    assign w_href  = w_tail[BUS_W-2];
    assign w_vsync = w_tail[BUS_W-3];
    assign w_data  = w_tail[OV_DATA_W-1:0];

    // All pins share one chain so a byte never skews against its pclk edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_chain[i] <= '0;
            end
            r_pclk_prev  <= 1'b0;
            r_href_prev  <= 1'b0;
            r_vsync_prev <= 1'b0;
            pclk_rise    <= 1'b0;
            href_lvl     <= 1'b0;
            href_fall    <= 1'b0;
            vsync_rise   <= 1'b0;
            vsync_fall   <= 1'b0;
            data_out     <= '0;
        end else begin
            r_chain[0] <= {pclk_in, href_in, vsync_in, data_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_pclk_prev  <= w_pclk;
            r_href_prev  <= w_href;
            r_vsync_prev <= w_vsync;
            pclk_rise    <= w_pclk & ~r_pclk_prev;
            href_lvl     <= w_href;
            href_fall    <= r_href_prev & ~w_href;
            vsync_rise   <= w_vsync & ~r_vsync_prev;
            vsync_fall   <= r_vsync_prev & ~w_vsync;
            data_out     <= w_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ov7670_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ov7670_capture                                              |
// | Brief   : Oversampled OV7670 capture: pairs bytes into RGB565 pixels  |
// |           and writes them to a linear frame buffer.                   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int ADDR_W      = 17,
    parameter int SYNC_STAGES = 2
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 ov_pclk,
    input  logic                 href,
    input  logic                 vsync,
    input  logic [OV_DATA_W-1:0] ov_data,
    output logic                 we,
    output logic [ADDR_W-1:0]    wAddr,
    output logic [RGB565_W-1:0]  wData,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic [7:0]           frame_cnt,
    output logic                 overflow_err,
    input  logic                 err_clr
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);

    logic                 w_pclk_rise;
    logic                 w_href;
    logic                 w_href_fall;
    logic                 w_vsync_rise;
    logic                 w_vsync_fall;
    logic [OV_DATA_W-1:0] w_data;

    logic [1:0]           r_state;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic [ADDR_W-1:0]    r_line_base;
    logic                 r_phase;
    logic [OV_DATA_W-1:0] r_hi;

    logic                 w_capturing;
    logic                 w_byte;
    logic                 w_pair;
    logic                 w_in_range;
    logic                 w_drop;

    ov7670_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .pclk_in    (ov_pclk),
        .href_in    (href),
        .vsync_in   (vsync),
        .data_in    (ov_data),
        .pclk_rise  (w_pclk_rise),
        .href_lvl   (w_href),
        .href_fall  (w_href_fall),
        .vsync_rise (w_vsync_rise),
        .vsync_fall (w_vsync_fall),
        .data_out   (w_data)
    );

    // Frame end and line end take precedence over any byte in the same cycle.
    assign w_capturing = enable && (r_state == ST_CAPTURE);
    assign w_byte      = w_capturing && !w_vsync_rise && !w_href_fall
                         && w_pclk_rise && w_href;
    assign w_pair      = w_byte && r_phase;
    assign w_in_range  = (r_x < XW'(IMG_W)) && (r_y < YW'(IMG_H));
    assign w_drop      = w_pair && !w_in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_line_base  <= '0;
            r_phase      <= 1'b0;
            r_hi         <= '0;
            we           <= 1'b0;
            wAddr        <= '0;
            wData        <= '0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            overflow_err <= 1'b0;
        end else begin
            we          <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;

            if (w_drop) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end

            if (!enable) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (w_vsync_fall) begin
                            frame_start <= 1'b1;
                            r_x         <= '0;
                            r_y         <= '0;
                            r_line_base <= '0;
                            r_phase     <= 1'b0;
                            r_state     <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (w_vsync_rise) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            r_state    <= ST_ARM;
                        end else if (w_href_fall) begin
                            // An odd trailing byte never forms a pixel.
                            r_phase <= 1'b0;
                            if (r_x != '0) begin
                                r_x <= '0;
                                if (r_y < YW'(IMG_H)) begin
                                    r_y         <= r_y + 1'b1;
                                    r_line_base <= r_line_base + ADDR_W'(IMG_W);
                                end
                            end
                        end else if (w_byte) begin
                            if (!r_phase) begin
                                r_hi    <= w_data;
                                r_phase <= 1'b1;
                            end else begin
                                if (w_in_range) begin
                                    we    <= 1'b1;
                                    wData <= rgb565_pack(r_hi, w_data);
                                    wAddr <= r_line_base + ADDR_W'(r_x);
                                end
                                if (r_x < XW'(IMG_W)) begin
                                    r_x <= r_x + 1'b1;
                                end
                                r_phase <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ov7670_capture                                           |
// | Brief   : Directed self-checking bench for ov7670_capture (4x2 image).|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ov7670_capture;

    localparam int IMG_W       = 4;
    localparam int IMG_H       = 2;
    localparam int ADDR_W      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 2;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              enable   = 1'b1;
    logic              ov_pclk  = 1'b0;
    logic              href     = 1'b0;
    logic              vsync    = 1'b0;
    logic              err_clr  = 1'b0;
    logic [7:0]        ov_data  = 8'h00;
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [15:0]       wData;
    logic              frame_start;
    logic              frame_done;
    logic [7:0]        frame_cnt;
    logic              overflow_err;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int rise2_cyc = 0;
    int fs_cnt    = 0;
    int fd_cnt    = 0;

    logic [ADDR_W-1:0] wr_addr [$];
    logic [15:0]       wr_data [$];
    int                wr_lat  [$];
    logic [7:0]        byte_q  [$];

    ov7670_capture #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ov_pclk      (ov_pclk),
        .href         (href),
        .vsync        (vsync),
        .ov_data      (ov_data),
        .we           (we),
        .wAddr        (wAddr),
        .wData        (wData),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .overflow_err (overflow_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            wr_addr.push_back(wAddr);
            wr_data.push_back(wData);
            wr_lat.push_back(cyc - rise2_cyc);
        end
        if (frame_start) fs_cnt++;
        if (frame_done)  fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input int idx, input logic [ADDR_W-1:0] a, input logic [15:0] d);
        if (idx < wr_addr.size()) begin
            chk($sformatf("wr%0d_addr", idx), 32'(wr_addr[idx]), 32'(a));
            chk($sformatf("wr%0d_data", idx), 32'(wr_data[idx]), 32'(d));
            chk($sformatf("wr%0d_lat", idx), wr_lat[idx], LAT);
        end else begin
            chk($sformatf("wr%0d_present", idx), wr_addr.size(), idx + 1);
        end
    endtask

    // pclk low for two clk, high for two clk; data changes with the fall.
    task automatic cam_byte(input logic [7:0] b, input bit second);
        ov_pclk = 1'b0;
        ov_data = b;
        repeat (2) @(negedge clk);
        ov_pclk = 1'b1;
        if (second) rise2_cyc = cyc;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_line();
        href = 1'b1;
        for (int i = 0; i < byte_q.size(); i++) begin
            cam_byte(byte_q[i], (i % 2) == 1);
        end
        ov_pclk = 1'b0;
        href    = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (10) @(negedge clk);
        vsync = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        // Reset with the camera toggling
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ov_pclk = ~ov_pclk;
            ov_data = 8'(i * 37);
            href    = (i % 2) == 1;
        end
        chk("reset_outs", {we, frame_start, frame_done, overflow_err, frame_cnt, wAddr, wData}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_line();
        chk("arm_no_we", wr_addr.size(), 0);
        chk("arm_no_start", fs_cnt, 0);

        // Frame 1: two full lines
        vsync_pulse();
        chk("f1_start", fs_cnt, 1);
        byte_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        send_line();
        chk_wr(0, 4'd0, 16'h1234);
        chk_wr(1, 4'd1, 16'h5678);
        chk_wr(2, 4'd2, 16'h9ABC);
        chk_wr(3, 4'd3, 16'hDEF0);
        chk("hold_outs", {we, wAddr, wData}, {1'b0, 4'd3, 16'hDEF0});
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_line();
        chk_wr(4, 4'd4, 16'h1122);
        chk_wr(7, 4'd7, 16'h7788);
        chk("f1_writes", wr_addr.size(), 8);
        vsync_pulse();
        chk("f1_done", fd_cnt, 1);
        chk("f1_cnt", frame_cnt, 1);
        chk("f2_start", fs_cnt, 2);

        // Frame 2: overlong line, then a line past IMG_H
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        send_line();
        chk("ovf_after_long", overflow_err, 1);
        chk_wr(11, 4'd3, 16'h0708);
        chk("long_writes", wr_addr.size(), 12);
        byte_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        send_line();
        chk_wr(12, 4'd4, 16'h2122);
        chk_wr(15, 4'd7, 16'h2728);
        byte_q = '{8'h31, 8'h32, 8'h33, 8'h34};
        send_line();
        chk("third_line_writes", wr_addr.size(), 16);
        chk("ovf_held", overflow_err, 1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", overflow_err, 0);
        vsync_pulse();
        chk("f2_cnt", frame_cnt, 2);

        // Frame 3: odd byte count
        byte_q = '{8'hC1, 8'hC2, 8'hC3};
        send_line();
        chk_wr(16, 4'd0, 16'hC1C2);
        byte_q = '{8'hD1, 8'hD2};
        send_line();
        chk_wr(17, 4'd4, 16'hD1D2);
        chk("odd_writes", wr_addr.size(), 18);
        vsync_pulse();
        chk("f3_cnt", frame_cnt, 3);
        chk("f4_start", fs_cnt, 4);

        // Frame 4: enable dropped mid-line
        href = 1'b1;
        cam_byte(8'hE1, 0);
        cam_byte(8'hE2, 1);
        cam_byte(8'hE3, 0);
        ov_pclk = 1'b0; ov_data = 8'hE4;
        repeat (2) @(negedge clk);
        ov_pclk = 1'b1; enable = 1'b0;
        repeat (2) @(negedge clk);
        cam_byte(8'hE5, 0);
        cam_byte(8'hE6, 1);
        ov_pclk = 1'b0; href = 1'b0;
        repeat (8) @(negedge clk);
        chk_wr(18, 4'd0, 16'hE1E2);
        chk("dis_writes", wr_addr.size(), 19);
        vsync_pulse();
        chk("dis_no_done", fd_cnt, 3);
        chk("dis_cnt", frame_cnt, 3);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        vsync_pulse();
        chk("reen_start", fs_cnt, 5);
        chk("reen_no_done", fd_cnt, 3);

        // Reset asserted mid-line
        href = 1'b1;
        cam_byte(8'hF1, 0);
        cam_byte(8'hF2, 1);
        cam_byte(8'hF3, 0);
        ov_pclk = 1'b0; ov_data = 8'hF4;
        repeat (2) @(negedge clk);
        ov_pclk = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("midreset_outs", {we, frame_start, frame_done, overflow_err, frame_cnt, wAddr, wData}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cam_byte(8'hF5, 0);
        cam_byte(8'hF6, 1);
        ov_pclk = 1'b0; href = 1'b0;
        repeat (8) @(negedge clk);
        chk_wr(19, 4'd0, 16'hF1F2);
        chk("rst_writes", wr_addr.size(), 20);
        vsync_pulse();
        chk("rst_no_done", fd_cnt, 3);
        chk("rst_start", fs_cnt, 6);
        byte_q = '{8'h5A, 8'hA5};
        send_line();
        chk_wr(20, 4'd0, 16'h5AA5);

        // vsync rises while href is still high
        href = 1'b1;
        cam_byte(8'h61, 0);
        cam_byte(8'h62, 1);
        cam_byte(8'h63, 0);
        vsync = 1'b1;
        repeat (10) @(negedge clk);
        href = 1'b0;
        repeat (4) @(negedge clk);
        chk("partial_done", fd_cnt, 4);
        chk("partial_cnt", frame_cnt, 1);
        chk_wr(21, 4'd4, 16'h6162);
        vsync = 1'b0;
        repeat (10) @(negedge clk);
        chk("partial_next_start", fs_cnt, 7);
        byte_q = '{8'h71, 8'h72};
        send_line();
        chk_wr(22, 4'd0, 16'h7172);
        chk("total_writes", wr_addr.size(), 23);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
